// File: rtl/fifo_burst_packer_pkg.sv
// Shared types for the FWFT burst packer.
// Counter widths come from cnt_w so every counter fits its top value.
package fifo_burst_packer_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    WAIT_OUT,
    FLUSHING
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/burst_out_reg.sv
// Output holding register of the burst packer.
// Loads a packed beat and holds it until the sink accepts it.
module burst_out_reg #(
  parameter int BITS  = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BITS*RATIO-1:0] load_data,
  input  logic [RATIO-1:0]      load_mask,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [BITS*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_mask,
  output logic                  out_last,
  output logic                  slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_mask  <= load_mask;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_fwft_burst_packer.sv
// Packs RATIO words from an FWFT FIFO into wide beats with burst framing.
// Idle auto-flush is built when FIFO_BURST_PACKER_AUTOFLUSH_EN is defined.
module fifo_fwft_burst_packer
  import fifo_burst_packer_pkg::*;
#(
  parameter int BITS          = 8,
  parameter int RATIO         = 4,
  parameter int BURST_LEN     = 8,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_ready,
  input  logic [BITS-1:0]       data_out,
  output logic                  shift_out,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_mask,
  output logic                  out_last,
  output logic                  busy
);

  if (RATIO < 2) begin : g_bad_ratio
    $error("RATIO must be at least 2");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must be at least 1");
  end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_tmo
    $error("FLUSH_TIMEOUT must be at least 1");
  end

  localparam int CW = cnt_w(RATIO);
  localparam int BW = cnt_w(BURST_LEN - 1);

  typedef logic [CW-1:0] acc_cnt_t;
  typedef logic [BW-1:0] beat_cnt_t;

  localparam acc_cnt_t FULL = acc_cnt_t'(RATIO);
  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BURST_LEN - 1);
  localparam logic [RATIO-1:0] ONE = {{(RATIO-1){1'b0}}, 1'b1};

  logic [RATIO-1:0][BITS-1:0] acc, acc_n;
  acc_cnt_t   acc_cnt, cnt_n;
  beat_cnt_t  beat_cnt;
  logic       flush_pend, pend, fc, auto_fc;
  logic       has, full, xfer, pop, slot_free, ld_last;
  logic [RATIO-1:0] ld_mask;
  state_t     state;

`ifdef FIFO_BURST_PACKER_AUTOFLUSH_EN
  localparam int IW = cnt_w(FLUSH_TIMEOUT);
  typedef logic [IW-1:0] idle_cnt_t;
  localparam idle_cnt_t TMO = idle_cnt_t'(FLUSH_TIMEOUT);

  idle_cnt_t idle_cnt;

  assign auto_fc = (idle_cnt == TMO);

  always_ff @(posedge clk) begin
    if (reset)
      idle_cnt <= '0;
    else if (pop || xfer)
      idle_cnt <= '0;
    else if (has && !auto_fc)
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign auto_fc = 1'b0;
`endif

  // A flush pulse acts in its own cycle, so it beats a same-cycle pop.
  always_comb begin
    pend    = flush_pend || flush;
    fc      = pend || auto_fc;
    has     = (acc_cnt != '0);
    full    = (acc_cnt == FULL);
    xfer    = slot_free && (full || (fc && has));
    pop     = data_ready && !reset && !pend && (!full || xfer);
    ld_last = fc || (beat_cnt == LAST_BEAT);
    ld_mask = (ONE << acc_cnt) - ONE;
    acc_n   = acc;
    cnt_n   = acc_cnt;
    if (xfer) begin
      acc_n = '0;
      cnt_n = '0;
    end
    if (pop) begin
      for (int i = 0; i < RATIO; i++)
        if (cnt_n == acc_cnt_t'(i))
          acc_n[i] = data_out;
      cnt_n = cnt_n + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_n;
      acc_cnt    <= cnt_n;
      flush_pend <= pend && has && !xfer;
      if (xfer)
        beat_cnt <= ld_last ? '0 : beat_cnt + 1'b1;
    end
  end

  always_comb begin
    if (!has)
      state = EMPTY;
    else if (flush_pend)
      state = FLUSHING;
    else if (full && !slot_free)
      state = WAIT_OUT;
    else
      state = FILLING;
  end

  assign shift_out = pop;
  assign busy = (state != EMPTY) || out_valid || flush_pend;

  burst_out_reg #(
    .BITS  (BITS),
    .RATIO (RATIO)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .load_data (acc),
    .load_mask (ld_mask),
    .load_last (ld_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_fifo_fwft_burst_packer.sv
// Directed bench for fifo_fwft_burst_packer (RATIO=4, BURST_LEN=2).
// Models the FWFT FIFO as a queue and records every accepted beat.
module tb_fifo_fwft_burst_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_ready;
  logic [7:0]  data_out;
  logic        shift_out;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int run = 0;
  int maxrun = 0;
  int k;
  logic sh;

  logic [7:0]  q[$];
  logic [31:0] bd[$];
  logic [3:0]  bm[$];
  logic        bl[$];

  logic [31:0] d;
  logic [3:0]  m;
  logic        l;

  fifo_fwft_burst_packer #(
    .BITS          (8),
    .RATIO         (4),
    .BURST_LEN     (2),
    .FLUSH_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_ready (data_ready),
    .data_out   (data_out),
    .shift_out  (shift_out),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    data_ready = (q.size() != 0);
    data_out   = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    refresh();
  endtask

  task automatic cyc();
    #1;
    sh = shift_out;
    if (out_valid && out_ready) begin
      bd.push_back(out_data);
      bm.push_back(out_mask);
      bl.push_back(out_last);
    end
    @(posedge clk);
    #1;
    if (sh) begin
      if (q.size() != 0) void'(q.pop_front());
      pops++;
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic get_beat(output logic [31:0] bdat, output logic [3:0] bmsk,
                          output logic blst);
    if (bd.size() != 0) begin
      bdat = bd.pop_front();
      bmsk = bm.pop_front();
      blst = bl.pop_front();
    end else begin
      bdat = 'x;
      bmsk = 'x;
      blst = 1'bx;
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    refresh();
    @(negedge clk);
    push(8'h99);
    cyc();
    cyc();
    chk("rst_shift", shift_out, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_mask", out_mask, 4'h0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nopop", pops, 0);
    q.delete();
    refresh();

    reset = 1'b0;
    out_ready = 1'b1;
    pops = 0; run = 0; maxrun = 0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    repeat (12) cyc();
    chk("s_pops", pops, 8);
    chk("s_run", maxrun, 8);
    chk("s_nbeats", bd.size(), 2);
    get_beat(d, m, l);
    chk("s_b0_data", d, 32'h44332211);
    chk("s_b0_mask", m, 4'hF);
    chk("s_b0_last", l, 1'b0);
    get_beat(d, m, l);
    chk("s_b1_data", d, 32'h88776655);
    chk("s_b1_mask", m, 4'hF);
    chk("s_b1_last", l, 1'b1);
    chk("s_idle_busy", busy, 1'b0);

    push(8'hAA);
    push(8'hBB);
    repeat (3) cyc();
    chk("f_busy", busy, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (3) cyc();
    get_beat(d, m, l);
    chk("f_data", d, 32'h0000BBAA);
    chk("f_mask", m, 4'h3);
    chk("f_last", l, 1'b1);
    for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
    repeat (7) cyc();
    get_beat(d, m, l);
    chk("f_next_data", d, 32'hC4C3C2C1);
    chk("f_next_last", l, 1'b0);

    out_ready = 1'b0;
    pops = 0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    repeat (14) cyc();
    chk("bp_pops", pops, 8);
    chk("bp_shift", shift_out, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_hold", out_data, 32'h04030201);
    out_ready = 1'b1;
    repeat (12) cyc();
    chk("bp_pops_all", pops, 12);
    chk("bp_nbeats", bd.size(), 3);
    get_beat(d, m, l);
    chk("bp_b0_data", d, 32'h04030201);
    chk("bp_b0_last", l, 1'b1);
    get_beat(d, m, l);
    chk("bp_b1_data", d, 32'h08070605);
    chk("bp_b1_last", l, 1'b0);
    get_beat(d, m, l);
    chk("bp_b2_data", d, 32'h0C0B0A09);
    chk("bp_b2_last", l, 1'b1);

    pops = 0;
    push(8'hD1);
    push(8'hD2);
    push(8'hD3);
    k = 0;
    while (pops < 3 && k < 10) begin
      cyc();
      k++;
    end
    chk("a_pops", pops, 3);
`ifdef FIFO_BURST_PACKER_AUTOFLUSH_EN
    k = 0;
    while (!out_valid && k < 40) begin
      cyc();
      k++;
    end
    chk("a_edges", k, 17);
    repeat (2) cyc();
`else
    repeat (100) cyc();
    chk("a_nobeat", bd.size(), 0);
    chk("a_busy", busy, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (3) cyc();
`endif
    get_beat(d, m, l);
    chk("a_data", d, 32'h00D3D2D1);
    chk("a_mask", m, 4'h7);
    chk("a_last", l, 1'b1);

    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    push(8'h31);
    push(8'h32);
    repeat (7) cyc();
    chk("r_pops", pops, 6);
    chk("r_held", out_data, 32'h44434241);
    push(8'h99);
    reset = 1'b1;
    cyc();
    chk("r_nopop", pops, 6);
    chk("r_shift", shift_out, 1'b0);
    chk("r_valid", out_valid, 1'b0);
    chk("r_data", out_data, 32'h0);
    chk("r_mask", out_mask, 4'h0);
    chk("r_last", out_last, 1'b0);
    chk("r_busy", busy, 1'b0);
    reset = 1'b0;
    out_ready = 1'b1;
    push(8'h9A);
    push(8'h9B);
    push(8'h9C);
    repeat (8) cyc();
    chk("r_nbeats", bd.size(), 1);
    get_beat(d, m, l);
    chk("r_fresh_data", d, 32'h9C9B9A99);
    chk("r_fresh_mask", m, 4'hF);
    chk("r_fresh_last", l, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
